mouse_pos_tracker: RTL

MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

---
 rtl/mouse_pos_tracker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mouse_pos_tracker.sv
// PS/2 mouse packet assembler and clamped cursor position tracker.
// Collects 3-byte movement packets and applies the signed deltas to a screen-bounded cursor.
module mouse_pos_tracker #(
  parameter int          XMAX    = 799,
  parameter int          YMAX    = 599,
  parameter int          XINIT   = 400,
  parameter int          YINIT   = 300,
  parameter logic [19:0] TIMEOUT = 20'd100000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        pos_valid
);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  localparam logic signed [13:0] XMAX_S  = 14'(XMAX);
  localparam logic signed [13:0] YMAX_S  = 14'(YMAX);
  localparam logic [11:0]        XMAX_U  = 12'(XMAX);
  localparam logic [11:0]        YMAX_U  = 12'(YMAX);
  localparam logic [11:0]        XINIT_U = 12'(XINIT);
  localparam logic [11:0]        YINIT_U = 12'(YINIT);

  state_t      r_state;
  logic [19:0] r_gap;
  logic        r_armed;
  logic        r_ovfY;
  logic        r_ovfX;
  logic        r_signY;
  logic        r_signX;
  logic [1:0]  r_btn;
  logic [7:0]  r_byte1;
  logic [11:0] r_xpos;
  logic [11:0] r_ypos;
  logic        r_left;
  logic        r_right;
  logic        r_posValid;

  logic               w_accept;
  logic               w_timeout;
  logic signed [13:0] w_dx;
  logic signed [13:0] w_dy;
  logic signed [13:0] w_newX;
  logic signed [13:0] w_newY;
  logic [11:0]        w_clampX;
  logic [11:0]        w_clampY;

  // r_armed holds off byte acceptance on the first edge after reset release.
  assign w_accept  = rx_valid && r_armed;
  assign w_timeout = (r_gap >= TIMEOUT - 20'd1);

  // The third byte is consumed straight from rx_data, so the update lands on its own edge.
  assign w_dx   = r_ovfX ? 14'sd0 : {{6{r_signX}}, r_byte1};
  assign w_dy   = r_ovfY ? 14'sd0 : {{6{r_signY}}, rx_data};
  assign w_newX = $signed({2'b00, r_xpos}) + w_dx;
  assign w_newY = $signed({2'b00, r_ypos}) - w_dy;

  always_comb begin
    if (w_newX < 14'sd0)      w_clampX = '0;
    else if (w_newX > XMAX_S) w_clampX = XMAX_U;
    else                      w_clampX = w_newX[11:0];
    if (w_newY < 14'sd0)      w_clampY = '0;
    else if (w_newY > YMAX_S) w_clampY = YMAX_U;
    else                      w_clampY = w_newY[11:0];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT_B0;
      r_gap      <= '0;
      r_armed    <= 1'b0;
      r_ovfY     <= 1'b0;
      r_ovfX     <= 1'b0;
      r_signY    <= 1'b0;
      r_signX    <= 1'b0;
      r_btn      <= '0;
      r_byte1    <= '0;
      r_xpos     <= XINIT_U;
      r_ypos     <= YINIT_U;
      r_left     <= 1'b0;
      r_right    <= 1'b0;
      r_posValid <= 1'b0;
    end else begin
      r_armed    <= 1'b1;
      r_posValid <= 1'b0;
      case (r_state)
        WAIT_B0: begin
          r_gap <= '0;
          // Bit 3 is always set in a genuine header byte; anything else is resync noise.
          if (w_accept && rx_data[3]) begin
            r_ovfY  <= rx_data[7];
            r_ovfX  <= rx_data[6];
            r_signY <= rx_data[5];
            r_signX <= rx_data[4];
            r_btn   <= rx_data[1:0];
            r_state <= WAIT_B1;
          end
        end
        WAIT_B1: begin
          if (w_accept) begin
            r_byte1 <= rx_data;
            r_gap   <= '0;
            r_state <= WAIT_B2;
          end else if (w_timeout) begin
            r_gap   <= '0;
            r_state <= WAIT_B0;
          end else begin
            r_gap <= r_gap + 20'd1;
          end
        end
        WAIT_B2: begin
          if (w_accept) begin
            r_xpos     <= w_clampX;
            r_ypos     <= w_clampY;
            r_left     <= r_btn[0];
            r_right    <= r_btn[1];
            r_posValid <= 1'b1;
            r_gap      <= '0;
            r_state    <= WAIT_B0;
          end else if (w_timeout) begin
            r_gap   <= '0;
            r_state <= WAIT_B0;
          end else begin
            r_gap <= r_gap + 20'd1;
          end
        end
        default: begin
          r_gap   <= '0;
          r_state <= WAIT_B0;
        end
      endcase
    end
  end

  assign xpos        = r_xpos;
  assign ypos        = r_ypos;
  assign mouse_left  = r_left;
  assign mouse_right = r_right;
  assign pos_valid   = r_posValid;

endmodule
